// File: rtl/wb_master_pkg.sv
// ============================================================================
// Module : wb_master_pkg
// Brief  : Shared types and constants for the Wishbone fill/check master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_pkg;

    localparam int WB_ADR_W = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        FILL  = 1'b0,
        CHECK = 1'b1
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/wb_fill_check_master.sv
// ============================================================================
// Module : wb_fill_check_master
// Brief  : Wishbone classic master that fills a word range with a pattern or
//          reads it back and counts mismatches.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fill_check_master
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [WB_ADR_W-1:0] base_adr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [31:0]         pattern_i,
    input  logic                incr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [LEN_W-1:0]    err_cnt_o,
    output logic [WB_ADR_W-1:0] first_err_adr_o,
    output logic                abort_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [WB_ADR_W-1:0] adr_o,
    output logic [3:0]          sel_o,
    output logic [31:0]         dat_o,
    input  logic [31:0]         dat_i,
    input  logic                ack_i,
    input  logic                err_i
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_e              state_q;
    mode_e               mode_q;
    logic                incr_q;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_ADR_W-1:0] first_err_adr_q;
    logic [31:0]         pat_q, pat_d;
    logic [LEN_W-1:0]    rem_q;
    logic [LEN_W-1:0]    err_cnt_q, err_cnt_d;
    logic [TMR_W-1:0]    tmr_q;
    logic                abort_q;
    logic                miss_d;

    assign adr_d     = adr_q + 1'b1;
    assign pat_d     = pat_q + {31'd0, incr_q};
    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    assign miss_d    = (mode_q == CHECK) && (dat_i != pat_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            mode_q          <= FILL;
            incr_q          <= 1'b0;
            adr_q           <= '0;
            pat_q           <= '0;
            rem_q           <= '0;
            tmr_q           <= '0;
            err_cnt_q       <= '0;
            first_err_adr_q <= '0;
            abort_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        abort_q         <= 1'b0;
                        err_cnt_q       <= '0;
                        first_err_adr_q <= '0;
                        if (len_i != '0) begin
                            adr_q   <= base_adr_i;
                            pat_q   <= pattern_i;
                            rem_q   <= len_i;
                            mode_q  <= mode_e'(mode_i);
                            incr_q  <= incr_i;
                            tmr_q   <= '0;
                            state_q <= XFER;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                XFER: begin
                    // A bus error ends the command even when ack arrives with it
                    if (err_i) begin
                        abort_q <= 1'b1;
                        state_q <= DONE;
                    end else if (ack_i) begin
                        adr_q <= adr_d;
                        pat_q <= pat_d;
                        rem_q <= rem_q - 1'b1;
                        tmr_q <= '0;
                        if (miss_d) begin
                            err_cnt_q <= err_cnt_d;
                            if (err_cnt_q == '0) begin
                                first_err_adr_q <= adr_q;
                            end
                        end
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DONE;
                        end
                    end else if (tmr_q == TMR_MAX) begin
                        abort_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign cyc_o           = (state_q == XFER);
    assign stb_o           = (state_q == XFER);
    assign we_o            = (state_q == XFER) && (mode_q == FILL);
    assign sel_o           = (state_q == XFER) ? 4'hF : 4'h0;
    assign adr_o           = adr_q;
    assign dat_o           = pat_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_adr_o = first_err_adr_q;
    assign abort_o         = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_fill_check_master.sv
// ============================================================================
// Module : tb_wb_fill_check_master
// Brief  : Self-checking bench with a registered-ack SRAM slave and a beat
//          scoreboard for wb_fill_check_master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_fill_check_master;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [29:0] base = '0;
    logic [15:0] len = '0;
    logic [31:0] pattern = '0;
    logic        incr = 1'b0;

    logic        busy_o, done_o, abort_o, cyc_o, stb_o, we_o;
    logic [15:0] err_cnt_o;
    logic [29:0] first_err_adr_o, adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;

    logic        ack_r;
    logic [31:0] rdat;
    logic        err_w;
    logic        ack_en = 1'b1;
    logic        err_arm = 1'b0;
    int          err_at = 0;
    int          ack_count;
    logic [31:0] mem [0:32767];

    int          checks = 0;
    int          errors = 0;
    beat_t       sb[$];

    always #5 clk = ~clk;

    wb_fill_check_master #(.TIMEOUT(255), .LEN_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .base_adr_i(base), .len_i(len), .pattern_i(pattern), .incr_i(incr),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .first_err_adr_o(first_err_adr_o), .abort_o(abort_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .sel_o(sel_o), .dat_o(dat_o), .dat_i(rdat), .ack_i(ack_r), .err_i(err_w)
    );

    assign err_w = err_arm && ack_r && (ack_count == err_at);

    // Registered-ack SRAM: ack toggles 0,1,0,1 while the strobe is held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r     <= 1'b0;
            ack_count <= 0;
        end else begin
            ack_r <= cyc_o && stb_o && !ack_r && ack_en;
            if (cyc_o && stb_o && !ack_r) rdat <= mem[adr_o[14:0]];
            if (cyc_o && stb_o && ack_r) begin
                ack_count <= ack_count + 1;
                if (we_o && !err_w) mem[adr_o[14:0]] <= dat_o;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cyc_o && stb_o && ack_r && !err_w) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_beat got we=%0b adr=%h want none", we_o, adr_o);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (we_o !== e.we || adr_o !== e.adr || sel_o !== 4'hF ||
                    (e.we && dat_o !== e.dat)) begin
                    errors++;
                    $display("FAIL sb_beat got we=%0b adr=%h sel=%h dat=%h want we=%0b adr=%h sel=f dat=%h",
                             we_o, adr_o, sel_o, dat_o, e.we, e.adr, e.dat);
                end
            end
        end
    end

    task automatic push_beats(input logic we, input logic [29:0] b, input int n,
                              input logic [31:0] p, input logic inc);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.we  = we;
            e.adr = b + 30'(i);
            e.dat = p + (inc ? 32'(i) : 32'd0);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic m, input logic [29:0] b, input logic [15:0] l,
                         input logic [31:0] p, input logic inc);
        mode = m; base = b; len = l; pattern = p; incr = inc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        checks++;
        if (cyc_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got cyc=%0b done=%0b busy=%0b want 0 0 0", name, cyc_o, done_o, busy_o);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left got %0d want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_all_reset(input string name);
        checks++;
        if ({cyc_o, stb_o, we_o, busy_o, done_o, abort_o} !== 6'b0 ||
            adr_o !== '0 || dat_o !== '0 || sel_o !== '0 ||
            err_cnt_o !== '0 || first_err_adr_o !== '0) begin
            errors++;
            $display("FAIL %s got cyc=%0b stb=%0b we=%0b busy=%0b done=%0b abort=%0b adr=%h dat=%h sel=%h ec=%h fa=%h want all 0",
                     name, cyc_o, stb_o, we_o, busy_o, done_o, abort_o, adr_o, dat_o, sel_o,
                     err_cnt_o, first_err_adr_o);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_reset("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_reset("after_release");
    endtask

    task automatic test_fill();
        int n;
        push_beats(1'b1, 30'h100, 4, 32'hA5A50000, 1'b1);
        issue(1'b0, 30'h100, 16'd4, 32'hA5A50000, 1'b1);
        wait_done(300, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL fill_latency got %0d want 8", n);
        end
        checks++;
        if (abort_o !== 1'b0 || busy_o !== 1'b1 || cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_done_state got abort=%0b busy=%0b cyc=%0b want 0 1 0", abort_o, busy_o, cyc_o);
        end
        check_idle_after("fill");
    endtask

    task automatic test_check_clean();
        int n;
        push_beats(1'b0, 30'h100, 4, 32'hA5A50000, 1'b1);
        issue(1'b1, 30'h100, 16'd4, 32'hA5A50000, 1'b1);
        wait_done(300, n);
        checks++;
        if (n != 8 || err_cnt_o !== 16'd0 || abort_o !== 1'b0) begin
            errors++;
            $display("FAIL check_clean got lat=%0d ec=%0d abort=%0b want 8 0 0", n, err_cnt_o, abort_o);
        end
        check_idle_after("check_clean");
    endtask

    task automatic test_check_corrupt();
        int n;
        push_beats(1'b1, 30'h102, 1, 32'h0, 1'b0);
        issue(1'b0, 30'h102, 16'd1, 32'h0, 1'b0);
        wait_done(300, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL corrupt_fill_latency got %0d want 2", n);
        end
        check_idle_after("corrupt_fill");

        push_beats(1'b0, 30'h100, 4, 32'hA5A50000, 1'b1);
        issue(1'b1, 30'h100, 16'd4, 32'hA5A50000, 1'b1);
        wait_done(300, n);
        checks++;
        if (err_cnt_o !== 16'd1 || first_err_adr_o !== 30'h102) begin
            errors++;
            $display("FAIL check_corrupt got ec=%0d fa=%h want 1 102", err_cnt_o, first_err_adr_o);
        end
        check_idle_after("check_corrupt");

        // Constant pattern: 0x101..0x103 all differ from the first word
        push_beats(1'b0, 30'h100, 4, 32'hA5A50000, 1'b0);
        issue(1'b1, 30'h100, 16'd4, 32'hA5A50000, 1'b0);
        wait_done(300, n);
        checks++;
        if (err_cnt_o !== 16'd3 || first_err_adr_o !== 30'h101) begin
            errors++;
            $display("FAIL check_noincr got ec=%0d fa=%h want 3 101", err_cnt_o, first_err_adr_o);
        end
        check_idle_after("check_noincr");
    endtask

    task automatic test_timeout();
        int n;
        ack_en = 1'b0;
        issue(1'b0, 30'h400, 16'd2, 32'h12345678, 1'b1);
        wait_done(400, n);
        checks++;
        if (n != 256 || abort_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout got lat=%0d abort=%0b want 256 1", n, abort_o);
        end
        check_idle_after("timeout");
        checks++;
        if (abort_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_sticky got %0b want 1", abort_o);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_zero_len();
        int n;
        issue(1'b0, 30'h800, 16'd0, 32'h0, 1'b0);
        wait_done(5, n);
        checks++;
        if (n != 0 || cyc_o !== 1'b0 || abort_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_len got lat=%0d cyc=%0b abort=%0b busy=%0b want 0 0 0 1",
                     n, cyc_o, abort_o, busy_o);
        end
        check_idle_after("zero_len");
    endtask

    task automatic test_err();
        int n;
        err_at  = ack_count + 1;
        err_arm = 1'b1;
        push_beats(1'b1, 30'h500, 1, 32'h11110000, 1'b1);
        issue(1'b0, 30'h500, 16'd4, 32'h11110000, 1'b1);
        wait_done(300, n);
        checks++;
        if (n != 4 || abort_o !== 1'b1 || adr_o !== 30'h501) begin
            errors++;
            $display("FAIL bus_err got lat=%0d abort=%0b adr=%h want 4 1 501", n, abort_o, adr_o);
        end
        err_arm = 1'b0;
        check_idle_after("bus_err");
    endtask

    task automatic test_back_to_back();
        int n;
        push_beats(1'b1, 30'h300, 2, 32'h77, 1'b0);
        issue(1'b0, 30'h300, 16'd2, 32'h77, 1'b0);
        mode = 1'b1; base = 30'h700; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, n);
        checks++;
        if (n != 3 || abort_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d abort=%0b want 3 0", n, abort_o);
        end
        @(negedge clk);
        push_beats(1'b0, 30'h300, 2, 32'h77, 1'b0);
        issue(1'b1, 30'h300, 16'd2, 32'h77, 1'b0);
        wait_done(300, n);
        checks++;
        if (n != 4 || err_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL back_to_back got lat=%0d ec=%0d want 4 0", n, err_cnt_o);
        end
        check_idle_after("back_to_back");
    endtask

    task automatic test_reset_mid();
        int  n;
        int  k;
        int  c0;
        logic saw_done;
        c0 = ack_count;
        push_beats(1'b1, 30'h200, 8, 32'h0BAD0000, 1'b1);
        issue(1'b0, 30'h200, 16'd8, 32'h0BAD0000, 1'b1);
        k = 0;
        while (ack_count < c0 + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ack_count < c0 + 2 || cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_beat3 got acks=%0d cyc=%0b want %0d 1", ack_count - c0, cyc_o, 2);
        end
        rst_n = 1'b0;
        #1;
        check_all_reset("mid_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== 1'b0 || cyc_o !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_no_done got activity=1 want 0");
        end
        push_beats(1'b1, 30'h600, 1, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 30'h600, 16'd1, 32'hDEADBEEF, 1'b0);
        wait_done(300, n);
        checks++;
        if (n != 2 || abort_o !== 1'b0) begin
            errors++;
            $display("FAIL restart got lat=%0d abort=%0b want 2 0", n, abort_o);
        end
        check_idle_after("restart");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_check_clean();
        test_check_corrupt();
        test_timeout();
        test_zero_len();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
